// File: rtl/sev_seg_pkg.sv
// Shared constants and hex-to-segment lookup for the seven-segment display driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package sev_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the active-low pattern for hex digit n (index 0 is rightmost).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/sev_seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sev_seg_decode
  import sev_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/sev_seg_mux.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous loading,
// leading-zero blanking, decimal points, 16-level brightness and anti-ghosting blanking.
module sev_seg_mux
  import sev_seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 16,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0]        dig_q, dig_d;
  logic [4*DIGITS-1:0]     shadow_num_q, disp_num_q;
  logic [DIGITS-1:0]       shadow_dp_q, disp_dp_q;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fs_q;

  logic                    slot_wrap, frame_wrap, active;
  logic [3:0]              nib_sel;
  logic [6:0]              dec_seg;
  logic [DIGITS-1:0]       lz_mask;
  logic                    zero_above;

  assign slot_wrap  = &cnt_q;
  assign frame_wrap = slot_wrap && (dig_q == DIG_W'(DIGITS - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    dig_d = dig_q;
    if (frame_wrap)     dig_d = '0;
    else if (slot_wrap) dig_d = dig_q + 1'b1;
  end

  assign nib_sel = disp_num_q[{dig_q, 2'b00} +: 4];

  sev_seg_decode u_decode (
    .nib_i (nib_sel),
    .seg_o (dec_seg)
  );

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (disp_num_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  assign active = en
               && (cnt_q >= REFRESH_BITS'(BLANK_CYCLES))
               && (cnt_q[REFRESH_BITS-1 -: 4] <= bright);

  always_comb begin
    an_d  = active ? ~(DIGITS'(1) << dig_q) : '1;
    seg_d = (blank_lz && lz_mask[dig_q]) ? SEG_BLANK : dec_seg;
    dp_d  = ~disp_dp_q[dig_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dig_q        <= '0;
      shadow_num_q <= '0;
      shadow_dp_q  <= '0;
      disp_num_q   <= '0;
      disp_dp_q    <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      if (load) begin
        shadow_num_q <= num;
        shadow_dp_q  <= dp_in;
      end
      // Display takes the pre-edge shadow, so a load on the boundary edge waits a frame.
      if (frame_wrap) begin
        disp_num_q <= shadow_num_q;
        disp_dp_q  <= shadow_dp_q;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fs_q  <= frame_wrap;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sev_seg_mux.sv
// Directed self-checking bench for sev_seg_mux (DIGITS=4, REFRESH_BITS=5, BLANK_CYCLES=2).
module tb_sev_seg_mux;

  localparam int DIGITS = 4;
  localparam int RB     = 5;
  localparam int BL     = 2;
  localparam int SLOT   = 32;
  localparam int FRAME  = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] num;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  bright;
  logic        en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [15:0] pats [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

  sev_seg_mux #(
    .DIGITS       (DIGITS),
    .REFRESH_BITS (RB),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .num         (num),
    .dp_in       (dp_in),
    .load        (load),
    .blank_lz    (blank_lz),
    .bright      (bright),
    .en          (en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic run_to(input int t);
    while (edges < t) step();
  endtask

  function automatic int next_frame(input int e);
    return (e / FRAME + 1) * FRAME;
  endfunction

  function automatic logic [27:0] segs_of(input logic [15:0] v);
    logic [27:0] r;
    for (int d = 0; d < 4; d++) r[7*d +: 7] = HEX[v[4*d +: 4]];
    return r;
  endfunction

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    num   = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Checks the middle of each digit slot in the frame whose boundary edge is f.
  task automatic chk_frame(input string tag, input int f, input logic [27:0] segs,
                           input logic [3:0] dps);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    for (int d = 0; d < 4; d++) begin
      run_to(f + SLOT*d + 16);
      ea = ~(4'b0001 << d);
      es = segs[7*d +: 7];
      ed = ~dps[d];
      chk($sformatf("%s_an%0d", tag, d), an, ea);
      chk($sformatf("%s_seg%0d", tag, d), seg, es);
      chk($sformatf("%s_dp%0d", tag, d), dp, ed);
    end
  endtask

  task automatic scan_slot(output int nlow, output int first, output int last);
    run_to((edges / SLOT + 1) * SLOT);
    nlow = 0; first = -1; last = -1;
    for (int c = 0; c < SLOT; c++) begin
      step();
      if (an != 4'hF) begin
        nlow++;
        if (first < 0) first = c;
        last = c;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          fs_at, f, bad, nlow, first, last, dig;
    logic [15:0] v_old, v_new;
    rst_n = 1'b0; num = '0; dp_in = '0; load = 1'b0;
    blank_lz = 1'b0; bright = 4'd15; en = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;
    edges = 0;

    // Reset asserted mid-slot must darken the pins without a clock edge.
    run_to(50);
    chk("pre_rst_an", an, 4'b1101);
    chk("pre_rst_seg", seg, HEX[0]);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_dp", dp, 1'b1);
    rst_n = 1'b1;
    edges = 0;

    fs_at = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (frame_start) begin
        fs_at = edges;
        break;
      end
    end
    chk("fs_first", fs_at, 128);
    run_to(129);
    chk("fs_width", frame_start, 1'b0);
    run_to(256);
    chk("fs_second", frame_start, 1'b1);

    for (int p = 0; p < 4; p++) begin
      do_load(pats[p], 4'b0000);
      f = next_frame(edges);
      chk_frame($sformatf("dec%0d", p), f, segs_of(pats[p]), 4'b0000);
    end

    // Two loads in one frame: only the last one may ever reach the pins.
    v_old = 16'h1234;
    v_new = 16'h5678;
    run_to(next_frame(edges) + 40);
    do_load(v_old, 4'b0000);
    run_to(edges + 30);
    do_load(v_new, 4'b0000);
    f = next_frame(edges);
    bad = 0;
    while (edges < f) begin
      step();
      dig = -1;
      for (int d = 0; d < 4; d++) if (an[d] == 1'b0) dig = d;
      if (dig >= 0 && seg == HEX[v_old[4*dig +: 4]]) bad++;
      if (edges == f - 16) chk("tear_old_d3", seg, HEX[15]);
    end
    chk_frame("tear_new", f, segs_of(v_new), 4'b0000);
    chk("tear_1234_seen", bad, 0);

    blank_lz = 1'b1;
    do_load(16'h0040, 4'b0000);
    f = next_frame(edges);
    chk_frame("lz40", f, {7'h7F, 7'h7F, 7'b0011001, 7'b1000000}, 4'b0000);
    do_load(16'h0000, 4'b0100);
    f = next_frame(edges);
    chk_frame("lz0dp", f, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b0100);
    blank_lz = 1'b0;

    bright = 4'd1;
    scan_slot(nlow, first, last);
    chk("b1_n", nlow, 2);
    chk("b1_first", first, 2);
    chk("b1_last", last, 3);
    bright = 4'd15;
    scan_slot(nlow, first, last);
    chk("b15_n", nlow, 30);
    chk("b15_first", first, 2);
    chk("b15_last", last, 31);
    bright = 4'd7;
    scan_slot(nlow, first, last);
    chk("b7_n", nlow, 14);
    chk("b7_last", last, 15);
    bright = 4'd0;
    scan_slot(nlow, first, last);
    chk("b0_n", nlow, 0);
    bright = 4'd15;
    en = 1'b0;
    scan_slot(nlow, first, last);
    chk("en0_n", nlow, 0);
    chk("en0_an", an, 4'hF);
    en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
